mux8_scanner: RTL and testbench

Sequential channel scanner that sits directly upstream of the 8:1 `mux8` and drives its select lines. It steps through all eight channels and holds each select value long enough for the mux output to settle. It samples `y` into a frame register and hands the assembled 8-bit frame downstream on a valid/ready handshake. It runs in one-shot or continuous mode and reports an overrun when the consumer is too slow.

---
 rtl/mux8_scan_pkg.sv | 6 +
 rtl/mux8_scan_ctr.sv | 30 +++
 rtl/mux8_scanner.sv | 58 +++++
 tb/tb_mux8_scanner.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mux8_scan_pkg.sv
// mux8_scan_pkg: shared constants and FSM state type for the mux8 channel scanner
package mux8_scan_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W = 3;
  typedef enum logic {IDLE, SCAN} scan_state_t;
endpackage

// File: rtl/mux8_scan_ctr.sv
// mux8_scan_ctr: settle counter and channel counter producing sample and frame-end strobes
module mux8_scan_ctr
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            clear,
  output logic [CH_W-1:0] ch,
  output logic            sample_en,
  output logic            frame_end
);
  logic [3:0] cnt;
  assign sample_en = run && cnt == 4'(SETTLE_CYCLES - 1);
  assign frame_end = sample_en && ch == CH_W'(NUM_CH - 1);
  // Hold each channel for SETTLE_CYCLES, then advance; the channel wraps to 0 after the last one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ch <= '0;
    end else if (clear) begin
      cnt <= '0;
      ch <= '0;
    end else if (run) begin
      cnt <= sample_en ? '0 : cnt + 4'd1;
      ch <= sample_en ? ch + CH_W'(1) : ch;
    end
endmodule

// File: rtl/mux8_scanner.sv
// mux8_scanner: steps mux8 selects through all channels and hands assembled frames out on valid/ready
module mux8_scanner
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  input  logic              y,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy,
  output logic              overrun
);
  scan_state_t state;
  logic [CH_W-1:0] ch;
  logic sample_en, frame_end, load;
  logic [NUM_CH-1:0] shadow, shadow_nxt;
  mux8_scan_ctr #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_ctr (
    .clk(clk),
    .rst(rst),
    .run(state == SCAN),
    .clear(state == IDLE),
    .ch(ch),
    .sample_en(sample_en),
    .frame_end(frame_end)
  );
  // The channel counter is a register, so the selects are glitch-free and sit at 0 while idle
  assign {s3, s2, s1} = ch;
  assign busy = state == SCAN;
  assign load = frame_end && (!frame_valid || frame_ready);
  // Shadow including the bit sampled this edge, so a frame-end load sees all eight channels
  always_comb begin
    shadow_nxt = shadow;
    if (sample_en) shadow_nxt[ch] = y;
  end
  // Scan FSM, frame output register, handshake and sticky overrun
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      frame <= '0;
      frame_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state == IDLE ? (start ? SCAN : IDLE) : (frame_end && !continuous ? IDLE : SCAN);
      shadow <= shadow_nxt;
      frame <= load ? shadow_nxt : frame;
      frame_valid <= load || (frame_valid && !frame_ready);
      overrun <= (state == IDLE && start) ? 1'b0 : overrun || (frame_end && !load);
    end
endmodule

// File: tb/tb_mux8_scanner.sv
// tb_mux8_scanner: directed tests of the mux8 scanner with a behavioural mux8 in the loop
module tb_mux8_scanner;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, continuous = 1'b0, frame_ready = 1'b1;
  logic [7:0] a = 8'h00;
  logic s1, s2, s3, y, frame_valid, busy, overrun;
  logic [7:0] frame;
  logic start_b = 1'b0, ready_b = 1'b1;
  logic [7:0] a_b = 8'h00;
  logic s1_b, s2_b, s3_b, y_b, valid_b, busy_b, overrun_b;
  logic [7:0] frame_b;
  logic [2:0] sel, sel_b;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;
  assign sel = {s3, s2, s1};
  assign sel_b = {s3_b, s2_b, s1_b};
  assign y = a[sel];
  assign y_b = a_b[sel_b];

  mux8_scanner #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .s1(s1), .s2(s2), .s3(s3), .y(y), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .overrun(overrun)
  );

  mux8_scanner #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .continuous(1'b0),
    .s1(s1_b), .s2(s2_b), .s3(s3_b), .y(y_b), .frame(frame_b), .frame_valid(valid_b),
    .frame_ready(ready_b), .busy(busy_b), .overrun(overrun_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++; if ({sel, frame, frame_valid, busy, overrun} !== 14'h0) begin errors++; $display("FAIL reset_outputs got sel=%0h frame=%0h v=%0b b=%0b o=%0b exp all 0", sel, frame, frame_valid, busy, overrun); end
    vectors++; if ({sel_b, frame_b, valid_b, busy_b} !== 13'h0) begin errors++; $display("FAIL reset_outputs_s1 got sel=%0h frame=%0h v=%0b b=%0b exp all 0", sel_b, frame_b, valid_b, busy_b); end
    rst = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0 || sel !== 3'd0) begin errors++; $display("FAIL idle_hold got busy=%0b sel=%0h exp 0 0", busy, sel); end
  endtask

  task automatic test_oneshot();
    a = 8'hA5; frame_ready = 1'b1; continuous = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int m = 0; m < 16; m++) begin
      vectors++; if (sel !== 3'(m / 2) || busy !== 1'b1) begin errors++; $display("FAIL oneshot_sel m=%0d got sel=%0h busy=%0b exp sel=%0h busy=1", m, sel, busy, m / 2); end
      tick();
    end
    vectors++; if (frame !== 8'hA5 || frame_valid !== 1'b1) begin errors++; $display("FAIL oneshot_frame got %0h v=%0b exp a5 v=1", frame, frame_valid); end
    vectors++; if (busy !== 1'b0 || sel !== 3'd0) begin errors++; $display("FAIL oneshot_done got busy=%0b sel=%0h exp 0 0", busy, sel); end
    tick();
    vectors++; if (frame_valid !== 1'b0 || frame !== 8'hA5) begin errors++; $display("FAIL oneshot_consume got v=%0b frame=%0h exp v=0 a5", frame_valid, frame); end
  endtask

  task automatic test_backpressure();
    frame_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (16) tick();
    a = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      vectors++; if (frame !== 8'hA5 || frame_valid !== 1'b1) begin errors++; $display("FAIL bp_hold i=%0d got %0h v=%0b exp a5 v=1", i, frame, frame_valid); end
      tick();
    end
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    vectors++; if (frame_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL bp_release got v=%0b o=%0b exp 0 0", frame_valid, overrun); end
    tick();
    vectors++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bp_stay_clear got v=%0b exp 0", frame_valid); end
  endtask

  task automatic test_continuous();
    a = 8'hA5; frame_ready = 1'b1; continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (16) tick();
    vectors++; if (frame !== 8'hA5 || frame_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cont_f1 got %0h v=%0b b=%0b exp a5 1 1", frame, frame_valid, busy); end
    a = 8'h3C;
    tick();
    vectors++; if (frame_valid !== 1'b0 || sel !== 3'd0) begin errors++; $display("FAIL cont_gap got v=%0b sel=%0h exp 0 0", frame_valid, sel); end
    repeat (15) tick();
    vectors++; if (frame !== 8'h3C || frame_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cont_f2 got %0h v=%0b b=%0b exp 3c 1 1", frame, frame_valid, busy); end
    continuous = 1'b0;
    repeat (16) tick();
    vectors++; if (frame !== 8'h3C || frame_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL cont_stop got %0h v=%0b b=%0b exp 3c 1 0", frame, frame_valid, busy); end
    tick();
  endtask

  task automatic test_overrun();
    a = 8'hA5; frame_ready = 1'b0; continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (16) tick();
    vectors++; if (frame !== 8'hA5 || frame_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_f1 got %0h v=%0b o=%0b exp a5 1 0", frame, frame_valid, overrun); end
    a = 8'h3C;
    repeat (16) tick();
    vectors++; if (frame !== 8'hA5 || overrun !== 1'b1 || frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_drop got %0h o=%0b v=%0b exp a5 1 1", frame, overrun, frame_valid); end
    continuous = 1'b0;
    repeat (16) tick();
    vectors++; if (busy !== 1'b0 || overrun !== 1'b1 || frame !== 8'hA5) begin errors++; $display("FAIL ovr_sticky got b=%0b o=%0b frame=%0h exp 0 1 a5", busy, overrun, frame); end
    frame_ready = 1'b1; tick();
    vectors++; if (frame_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_consume got v=%0b o=%0b exp 0 1", frame_valid, overrun); end
    a = 8'h81;
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (overrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovr_clear got o=%0b b=%0b exp 0 1", overrun, busy); end
    repeat (16) tick();
    vectors++; if (frame !== 8'h81 || frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_next got %0h v=%0b exp 81 1", frame, frame_valid); end
  endtask

  task automatic test_reset_mid();
    frame_ready = 1'b0; a = 8'h5A;
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    vectors++; if (sel !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got sel=%0h b=%0b exp 3 1", sel, busy); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({sel, frame, frame_valid, busy, overrun} !== 14'h0) begin errors++; $display("FAIL rmid_async got sel=%0h frame=%0h v=%0b b=%0b o=%0b exp all 0", sel, frame, frame_valid, busy, overrun); end
    tick();
    rst = 1'b0;
    repeat (20) tick();
    vectors++; if (busy !== 1'b0 || frame_valid !== 1'b0 || sel !== 3'd0) begin errors++; $display("FAIL rmid_noresume got b=%0b v=%0b sel=%0h exp 0 0 0", busy, frame_valid, sel); end
    frame_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (16) tick();
    vectors++; if (frame !== 8'h5A || frame_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after got %0h v=%0b b=%0b exp 5a 1 0", frame, frame_valid, busy); end
  endtask

  task automatic test_back_to_back_start_s1();
    a_b = 8'h96; ready_b = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick(); tick();
    start_b = 1'b1; tick(); start_b = 1'b0;
    vectors++; if (sel_b !== 3'd3 || busy_b !== 1'b1) begin errors++; $display("FAIL s1_restart got sel=%0h b=%0b exp 3 1", sel_b, busy_b); end
    repeat (4) tick();
    vectors++; if (sel_b !== 3'd7 || valid_b !== 1'b0) begin errors++; $display("FAIL s1_last got sel=%0h v=%0b exp 7 0", sel_b, valid_b); end
    tick();
    vectors++; if (frame_b !== 8'h96 || valid_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL s1_frame got %0h v=%0b b=%0b exp 96 1 0", frame_b, valid_b, busy_b); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_backpressure();
    test_continuous();
    test_overrun();
    test_reset_mid();
    test_back_to_back_start_s1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
